// File: rtl/daq_ddu_arbiter.sv
// Arbitrates the 16-bit DDU output link between the DAQ event builder (source 0)
// and the test/monitor generator (source 1), one whole packet at a time.
module daq_ddu_arbiter #(
    parameter int MIN_GAP = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LINK_EN,
    input  logic [15:0]      S0_DATA,
    input  logic             S0_VLD,
    input  logic             S0_LAST,
    output logic             S0_RDY,
    input  logic [15:0]      S1_DATA,
    input  logic             S1_VLD,
    input  logic             S1_LAST,
    output logic             S1_RDY,
    output logic [15:0]      TXD,
    output logic             TXD_VLD,
    output logic             BUSY,
    output logic             ACTIVE_SRC,
    output logic             ABORT,
    output logic [CNT_W-1:0] PKT_CNT0,
    output logic [CNT_W-1:0] PKT_CNT1,
    output logic [7:0]       ERR_CNT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND0 = 2'd1,
        SEND1 = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 1);
    localparam logic [7:0]  GAP_LOAD    = 8'(MIN_GAP);

    logic [15:0] src_data [2];
    logic [1:0]  src_vld;
    logic [1:0]  src_last;

    assign src_data[0] = S0_DATA;
    assign src_data[1] = S1_DATA;
    assign src_vld     = {S1_VLD, S0_VLD};
    assign src_last    = {S1_LAST, S0_LAST};

    state_t      state_q, state_d;
    logic [15:0] txd_q, txd_d;
    logic        txd_vld_q, txd_vld_d;
    logic [1:0]  rdy_q, rdy_d;
    logic        busy_q, busy_d;
    logic        active_src_q, active_src_d;
    logic        abort_q, abort_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [1:0]  pkt_done;
    logic [CNT_W-1:0] pkt_cnt_q [2];
    logic [CNT_W-1:0] pkt_cnt_d [2];

    logic cur_src;
    logic xfer;
    logic grant_src;

    // In SENDx the matching ready flop is high, so a transfer is just VLD && RDY.
    assign cur_src   = (state_q == SEND1);
    assign xfer      = src_vld[cur_src] & rdy_q[cur_src];
    assign grant_src = !(src_vld[0] && (!src_vld[1] || active_src_q));

    always_comb begin
        state_d      = state_q;
        txd_d        = '0;
        txd_vld_d    = 1'b0;
        active_src_d = active_src_q;
        abort_d      = 1'b0;
        stall_cnt_d  = stall_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        err_cnt_d    = err_cnt_q;
        pkt_done     = '0;

        case (state_q)
            IDLE: begin
                if (LINK_EN && (|src_vld)) begin
                    state_d      = grant_src ? SEND1 : SEND0;
                    active_src_d = grant_src;
                    stall_cnt_d  = '0;
                end
            end
            SEND0, SEND1: begin
                if (xfer) begin
                    txd_d       = src_data[cur_src];
                    txd_vld_d   = 1'b1;
                    stall_cnt_d = '0;
                    if (src_last[cur_src]) begin
                        pkt_done[cur_src] = 1'b1;
                        state_d           = GAP;
                        gap_cnt_d         = GAP_LOAD;
                    end
                end else if (stall_cnt_q == STALL_LIMIT) begin
                    // Stalled source: drop the rest of the packet and free the link.
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                    abort_d   = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign rdy_d[gi] = (state_d == ((gi == 0) ? SEND0 : SEND1));

            always_comb begin
                pkt_cnt_d[gi] = pkt_cnt_q[gi] + CNT_W'(pkt_done[gi]);
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    pkt_cnt_q[gi] <= '0;
                end else begin
                    pkt_cnt_q[gi] <= pkt_cnt_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            txd_q        <= '0;
            txd_vld_q    <= 1'b0;
            rdy_q        <= '0;
            busy_q       <= 1'b0;
            active_src_q <= 1'b1;
            abort_q      <= 1'b0;
            stall_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            txd_q        <= txd_d;
            txd_vld_q    <= txd_vld_d;
            rdy_q        <= rdy_d;
            busy_q       <= busy_d;
            active_src_q <= active_src_d;
            abort_q      <= abort_d;
            stall_cnt_q  <= stall_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign S0_RDY     = rdy_q[0];
    assign S1_RDY     = rdy_q[1];
    assign TXD        = txd_q;
    assign TXD_VLD    = txd_vld_q;
    assign BUSY       = busy_q;
    assign ACTIVE_SRC = active_src_q;
    assign ABORT      = abort_q;
    assign PKT_CNT0   = pkt_cnt_q[0];
    assign PKT_CNT1   = pkt_cnt_q[1];
    assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_daq_ddu_arbiter.sv
// Scoreboard bench for daq_ddu_arbiter: words accepted by the arbiter are queued
// and compared in order against TXD; a second small instance covers MIN_GAP=0 and counter wrap.
module tb_daq_ddu_arbiter;

    localparam int MIN_GAP_A = 4;
    localparam int TIMEOUT_A = 8;
    localparam int GAP_EXP   = MIN_GAP_A + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        link_en;
    logic [15:0] s_data [2];
    logic [1:0]  s_vld;
    logic [1:0]  s_last;
    logic        s0_rdy, s1_rdy;
    logic [15:0] txd;
    logic        txd_vld, busy, active_src, abort;
    logic [15:0] pkt0, pkt1;
    logic [7:0]  err;

    logic        rst_b;
    logic [15:0] b_s0_data;
    logic        b_s0_vld, b_s0_last;
    logic        b_s0_rdy, b_s1_rdy;
    logic [15:0] b_txd;
    logic        b_txd_vld, b_busy, b_active_src, b_abort;
    logic [3:0]  b_pkt0, b_pkt1;
    logic [7:0]  b_err;

    always #5 clk = ~clk;

    daq_ddu_arbiter #(.MIN_GAP(MIN_GAP_A), .TIMEOUT(TIMEOUT_A), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst), .LINK_EN(link_en),
        .S0_DATA(s_data[0]), .S0_VLD(s_vld[0]), .S0_LAST(s_last[0]), .S0_RDY(s0_rdy),
        .S1_DATA(s_data[1]), .S1_VLD(s_vld[1]), .S1_LAST(s_last[1]), .S1_RDY(s1_rdy),
        .TXD(txd), .TXD_VLD(txd_vld), .BUSY(busy), .ACTIVE_SRC(active_src),
        .ABORT(abort), .PKT_CNT0(pkt0), .PKT_CNT1(pkt1), .ERR_CNT(err)
    );

    daq_ddu_arbiter #(.MIN_GAP(0), .TIMEOUT(TIMEOUT_A), .CNT_W(4)) dut_b (
        .CLK(clk), .RST(rst_b), .LINK_EN(1'b1),
        .S0_DATA(b_s0_data), .S0_VLD(b_s0_vld), .S0_LAST(b_s0_last), .S0_RDY(b_s0_rdy),
        .S1_DATA(16'h0000), .S1_VLD(1'b0), .S1_LAST(1'b0), .S1_RDY(b_s1_rdy),
        .TXD(b_txd), .TXD_VLD(b_txd_vld), .BUSY(b_busy), .ACTIVE_SRC(b_active_src),
        .ABORT(b_abort), .PKT_CNT0(b_pkt0), .PKT_CNT1(b_pkt1), .ERR_CNT(b_err)
    );

    int checks = 0;
    int errors = 0;
    int exp_pkt [2];
    int exp_err;
    logic [15:0] exp_q [$];
    bit exp_grant [$];

    bit mon_en = 1'b1;
    bit gap_mode = 1'b0;
    bit have_prev = 1'b0;
    bit prev_vld = 1'b0;
    int low_run = 0;
    int abort_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic src_rdy(input int s);
        return (s == 0) ? s0_rdy : s1_rdy;
    endfunction

    task automatic chk_reset(input string pfx);
        chk({pfx, "_txd"}, txd, 0);
        chk({pfx, "_txd_vld"}, txd_vld, 0);
        chk({pfx, "_s0_rdy"}, s0_rdy, 0);
        chk({pfx, "_s1_rdy"}, s1_rdy, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_abort"}, abort, 0);
        chk({pfx, "_active_src"}, active_src, 1);
        chk({pfx, "_pkt_cnt0"}, pkt0, 0);
        chk({pfx, "_pkt_cnt1"}, pkt1, 0);
        chk({pfx, "_err_cnt"}, err, 0);
    endtask

    // Drives one packet; called on a falling edge, returns on a falling edge.
    task automatic send_pkt(input int src, input int n, input logic [15:0] base,
                            input int stall_at, input int stall_len, input bit no_last,
                            output int first_wait);
        int waits;
        first_wait = -1;
        for (int i = 0; i < n; i++) begin
            if (i == stall_at && stall_len > 0) begin
                s_vld[src] = 1'b0;
                repeat (stall_len) @(negedge clk);
            end
            s_data[src] = base * 16'(i + 1);
            s_last[src] = (i == n - 1) && !no_last;
            s_vld[src]  = 1'b1;
            waits = 0;
            while (!src_rdy(src) && waits < 200) begin
                @(negedge clk);
                waits++;
            end
            if (i == 0) first_wait = waits;
            if (waits >= 200) begin
                chk("rdy_wait_expired", waits, 0);
                s_vld[src]  = 1'b0;
                s_last[src] = 1'b0;
                return;
            end
            exp_q.push_back(s_data[src]);
            @(negedge clk);
        end
        s_vld[src]  = 1'b0;
        s_last[src] = 1'b0;
        if (!no_last) exp_pkt[src]++;
    endtask

    always @(negedge clk) begin
        if (abort) abort_seen++;
        if (mon_en && !rst) begin
            if (txd_vld) begin
                if (!prev_vld) begin
                    if (gap_mode && have_prev) chk("idle_gap", low_run, GAP_EXP);
                    have_prev = 1'b1;
                    if (exp_grant.size() != 0) chk("grant_src", active_src, exp_grant.pop_front());
                end
                if (exp_q.size() == 0) chk("txd_unexpected", {16'd0, txd}, 32'h1_0000);
                else chk("txd", txd, exp_q.pop_front());
                low_run = 0;
            end else begin
                low_run++;
            end
        end
        prev_vld = txd_vld;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fw, rdy_hi, xfers, ab_at, ab0, nwords, low;
        bit done, started;

        rst = 1'b1; rst_b = 1'b1; link_en = 1'b1;
        s_vld = '0; s_last = '0; s_data[0] = '0; s_data[1] = '0;
        b_s0_data = 16'hC0DE; b_s0_vld = 1'b0; b_s0_last = 1'b1;
        exp_pkt[0] = 0; exp_pkt[1] = 0; exp_err = 0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single source, five words
        send_pkt(0, 5, 16'h1111, -1, 0, 0, fw);
        chk("single_first_rdy_latency", fw, 1);
        chk("single_pkt_cnt0", pkt0, exp_pkt[0]);
        repeat (8) @(negedge clk);

        // Round robin from reset: 0,1,0,1 with fixed idle gaps
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_pkt[0] = 0; exp_pkt[1] = 0;
        @(negedge clk);
        exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
        exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
        gap_mode = 1'b1; have_prev = 1'b0;
        fork
            begin
                send_pkt(0, 3, 16'h0A01, -1, 0, 0, fw);
                send_pkt(0, 3, 16'h0A11, -1, 0, 0, fw);
            end
            begin
                int fw1;
                send_pkt(1, 3, 16'h0B01, -1, 0, 0, fw1);
                send_pkt(1, 3, 16'h0B11, -1, 0, 0, fw1);
            end
        join
        repeat (3) @(negedge clk);
        gap_mode = 1'b0;
        chk("rr_pkt_cnt0", pkt0, 2);
        chk("rr_pkt_cnt1", pkt1, 2);
        chk("rr_grants_consumed", exp_grant.size(), 0);
        repeat (8) @(negedge clk);

        // Stall timeout: two words then silence
        ab0 = abort_seen;
        send_pkt(1, 2, 16'h0C01, -1, 0, 1, fw);
        ab_at = -1;
        exp_err++;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (abort && ab_at < 0) begin
                ab_at = k;
                chk("abort_s1_rdy", s1_rdy, 0);
                chk("abort_err_cnt", err, exp_err);
            end
        end
        chk("abort_latency", ab_at, TIMEOUT_A);
        chk("abort_pulses", abort_seen - ab0, 1);
        chk("abort_pkt_cnt1", pkt1, exp_pkt[1]);

        // Stall of TIMEOUT-1 cycles completes normally
        ab0 = abort_seen;
        send_pkt(1, 4, 16'h0C11, 2, TIMEOUT_A - 1, 0, fw);
        repeat (10) @(negedge clk);
        chk("late_vld_no_abort", abort_seen - ab0, 0);
        chk("late_vld_pkt_cnt1", pkt1, exp_pkt[1]);
        chk("late_vld_err_cnt", err, exp_err);

        // LINK_EN gating
        link_en = 1'b0;
        s_data[0] = 16'h0303; s_last[0] = 1'b0; s_vld[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("nolink_s0_rdy", s0_rdy, 0);
            chk("nolink_txd_vld", txd_vld, 0);
        end
        link_en = 1'b1;
        fork
            send_pkt(0, 5, 16'h0303, -1, 0, 0, fw);
            begin
                repeat (3) @(negedge clk);
                link_en = 1'b0;
            end
        join
        chk("link_grant_latency", fw, 1);
        chk("link_drop_pkt_cnt0", pkt0, exp_pkt[0]);
        s_data[0] = 16'h0404; s_last[0] = 1'b1; s_vld[0] = 1'b1;
        rdy_hi = 0;
        repeat (14) begin
            @(negedge clk);
            if (s0_rdy) rdy_hi++;
        end
        chk("link_low_no_regrant", rdy_hi, 0);
        s_vld[0] = 1'b0; s_last[0] = 1'b0;
        link_en = 1'b1;
        repeat (3) @(negedge clk);

        // Reset during word 3 of a 6-word packet
        mon_en = 1'b0;
        s_vld[0] = 1'b1; s_last[0] = 1'b0;
        xfers = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            s_data[0] = 16'(16'h7001 + xfers);
            if (s0_rdy) begin
                if (xfers == 2) begin
                    rst = 1'b1;
                    done = 1'b1;
                end else begin
                    xfers++;
                end
            end
            if (!done) @(negedge clk);
        end
        @(negedge clk);
        chk("rst_mid_reached", done, 1);
        chk_reset("rst_mid");
        rst = 1'b0;
        s_vld[0] = 1'b0; s_data[0] = '0;
        @(negedge clk);
        exp_q.delete(); exp_grant.delete();
        exp_pkt[0] = 0; exp_pkt[1] = 0; exp_err = 0;
        mon_en = 1'b1;
        exp_grant.push_back(1'b0); exp_grant.push_back(1'b1);
        fork
            send_pkt(0, 2, 16'h0E01, -1, 0, 0, fw);
            begin
                int fw2;
                send_pkt(1, 2, 16'h0F01, -1, 0, 0, fw2);
            end
        join
        repeat (8) @(negedge clk);
        chk("post_rst_grants_consumed", exp_grant.size(), 0);
        chk("post_rst_pkt_cnt0", pkt0, exp_pkt[0]);

        // 257 aborts saturate ERR_CNT at 255
        ab0 = abort_seen;
        for (int i = 0; i < 257; i++) begin
            send_pkt(0, 1, 16'(16'hD000 + i), -1, 0, 1, fw);
            repeat (16) @(negedge clk);
            if (exp_err < 255) exp_err++;
            if (i == 0 || i == 254) chk("err_cnt_count", err, exp_err);
        end
        chk("err_cnt_saturated", err, 255);
        chk("sat_abort_pulses", abort_seen - ab0, 257);
        chk("sat_pkt_cnt0", pkt0, exp_pkt[0]);
        chk("scoreboard_drained", exp_q.size(), 0);

        // MIN_GAP=0 instance: single-word packets back to back, 4-bit counter wraps
        rst_b = 1'b0;
        @(negedge clk);
        b_s0_vld = 1'b1;
        nwords = 0; low = 0; started = 1'b0;
        for (int c = 0; c < 200 && nwords < 17; c++) begin
            @(negedge clk);
            if (b_txd_vld) begin
                chk("b_txd", b_txd, 16'hC0DE);
                if (started) chk("b_idle_gap", low, 2);
                started = 1'b1;
                low = 0;
                nwords++;
                if (nwords >= 15) chk("b_pkt_cnt_wrap", b_pkt0, nwords % 16);
            end else begin
                low++;
            end
        end
        chk("b_word_count", nwords, 17);
        b_s0_vld = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
